sram_mem_responder: RTL and testbench

- Responder side of the MEM-stage data-memory interface. Serves 32-bit word load/store requests from the pipeline's memory stage.
- Drives an external 16-bit asynchronous SRAM, splitting each word into two half-word accesses with programmable wait states.
- Deasserts `ready` while an access is in flight; the pipeline top combines this into its global freeze.

---
 rtl/sram_mem_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_sram_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_responder.sv
// ---------------------------------------------------------------------------
// sram_mem_responder
//
// Responder side of the MEM-stage data-memory interface. Each 32-bit word
// load or store from the pipeline is turned into two half-word accesses on
// an external 16-bit asynchronous SRAM (low half first, then high half).
// Each half-word phase holds the SRAM pins for WAIT_CYCLES cycles. While an
// access is in flight ready_o is low so the pipeline freezes.
//
// Optional feature (macro SRAM_ADDR_CHECK_EN):
//   When defined, out-of-range or misaligned requests raise addr_err_o,
//   skip the SRAM entirely, finish in one cycle and return all-ones load
//   data. When undefined, addr_err_o is tied low and every address is
//   mapped by truncation.
//
// Parameters:
//   DATA_BASE    byte address that maps to SRAM word 0
//   WAIT_CYCLES  cycles per half-word phase (1..15)
//   SRAM_ADDR_W  SRAM half-word address width
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   rd_en_i        load request
//   wr_en_i        store request (never together with rd_en_i)
//   address_i      byte address of the request
//   wr_data_i      store data
//   rd_data_o      load data, valid in the cycle ready_o rises after a load
//   ready_o        0 = request pending, pipeline must freeze
//   addr_err_o     erroneous request flag (0 without the optional feature)
//   sram_addr_o    SRAM half-word address
//   sram_dq_out_o  write data towards the SRAM
//   sram_dq_oe_o   1 = controller drives the DQ bus
//   sram_dq_in_i   read data from the SRAM
//   sram_we_n_o    active-low SRAM write strobe
// ---------------------------------------------------------------------------
module sram_mem_responder #(
  parameter int unsigned DATA_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_ADDR_W = 18
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rd_en_i,
  input  logic                   wr_en_i,
  input  logic [31:0]            address_i,
  input  logic [31:0]            wr_data_i,
  output logic [31:0]            rd_data_o,
  output logic                   ready_o,
  output logic                   addr_err_o,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  output logic [15:0]            sram_dq_out_o,
  output logic                   sram_dq_oe_o,
  input  logic [15:0]            sram_dq_in_i,
  output logic                   sram_we_n_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] CNT_RELOAD = 4'(WAIT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [31:0]            rd_data_q, rd_data_d;
  logic                   we_n_q, we_n_d;
  logic                   oe_q, oe_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]            dq_q, dq_d;
  logic                   is_wr_q, is_wr_d;
  logic [15:0]            wr_hi_q, wr_hi_d;

  logic                   req;
  logic [31:0]            offset;
  logic [29:0]            word;
  logic [SRAM_ADDR_W-1:0] addr_lo;
  logic                   addr_err;
  logic                   unused_ok;

  // Map the byte address into SRAM half-word space. The word index is
  // truncated to the SRAM size; the low half of a word lives at the even
  // half-word address and the high half at the following odd one.
  assign req     = rd_en_i | wr_en_i;
  assign offset  = address_i - 32'(DATA_BASE);
  assign word    = offset[31:2];
  assign addr_lo = {word[SRAM_ADDR_W-2:0], 1'b0};

  // Bits dropped by the mapping, gathered so they are visibly accounted for.
  assign unused_ok = ^{offset[1:0], word[29:SRAM_ADDR_W-1]};

  // Address checking: a request is rejected when it lies below the data
  // base, is not word aligned, or falls past the end of the SRAM. Without
  // the feature every address is accepted and simply truncated.
`ifdef SRAM_ADDR_CHECK_EN
  logic word_oor;
  assign word_oor = |(word >> (SRAM_ADDR_W - 1));
  assign addr_err = req & ((address_i < 32'(DATA_BASE)) |
                           (address_i[1:0] != 2'b00) |
                           word_oor);
`else
  assign addr_err = 1'b0;
`endif

  // The pipeline is released in the DONE cycle: ready stays low for any
  // pending request until the access has fully completed.
  assign ready_o    = ~(req & (state_q != DONE));
  assign addr_err_o = addr_err;

  assign rd_data_o     = rd_data_q;
  assign sram_addr_o   = addr_q;
  assign sram_dq_out_o = dq_q;
  assign sram_dq_oe_o  = oe_q;
  assign sram_we_n_o   = we_n_q;

  // Next-state and next-output logic. The SRAM pin registers are loaded
  // with the values belonging to the state being entered, so the pins show
  // the phase's address/data/strobe for exactly the cycles the FSM spends
  // in that phase. The request type and upper store half are captured on
  // entry so an access completes consistently even if the requester drops
  // its request part-way through. Load halves are sampled on the last cycle
  // of each phase, when the SRAM has had the full wait time to respond.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    we_n_d    = 1'b1;
    oe_d      = 1'b0;
    addr_d    = addr_q;
    dq_d      = dq_q;
    is_wr_d   = is_wr_q;
    wr_hi_d   = wr_hi_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (addr_err) begin
            state_d = DONE;
            if (rd_en_i) begin
              rd_data_d = 32'hFFFF_FFFF;
            end
          end else begin
            state_d = LOW;
            cnt_d   = CNT_RELOAD;
            addr_d  = addr_lo;
            is_wr_d = wr_en_i;
            wr_hi_d = wr_data_i[31:16];
            if (wr_en_i) begin
              we_n_d = 1'b0;
              oe_d   = 1'b1;
              dq_d   = wr_data_i[15:0];
            end
          end
        end
      end

      LOW: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          if (is_wr_q) begin
            we_n_d = 1'b0;
            oe_d   = 1'b1;
          end
        end else begin
          state_d = HIGH;
          cnt_d   = CNT_RELOAD;
          addr_d  = {addr_q[SRAM_ADDR_W-1:1], 1'b1};
          if (is_wr_q) begin
            we_n_d = 1'b0;
            oe_d   = 1'b1;
            dq_d   = wr_hi_q;
          end else begin
            rd_data_d[15:0] = sram_dq_in_i;
          end
        end
      end

      HIGH: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          if (is_wr_q) begin
            we_n_d = 1'b0;
            oe_d   = 1'b1;
          end
        end else begin
          state_d = DONE;
          if (!is_wr_q) begin
            rd_data_d[31:16] = sram_dq_in_i;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pin registers. Reset abandons any access in flight and
  // releases the SRAM immediately; a store cut short may leave only its
  // low half written.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rd_data_q <= 32'd0;
      we_n_q    <= 1'b1;
      oe_q      <= 1'b0;
      addr_q    <= '0;
      dq_q      <= 16'd0;
      is_wr_q   <= 1'b0;
      wr_hi_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      we_n_q    <= we_n_d;
      oe_q      <= oe_d;
      addr_q    <= addr_d;
      dq_q      <= dq_d;
      is_wr_q   <= is_wr_d;
      wr_hi_q   <= wr_hi_d;
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_mem_responder
//
// Bench for sram_mem_responder. Two instances share clock and reset: dut1
// with one wait cycle per phase and dut3 with three. Each drives its own
// behavioural 16-bit SRAM. A write only lands in the SRAM model when the
// strobe has been held on one address for a full phase, as a real part
// needs the programmed pulse width.
// ---------------------------------------------------------------------------
module tb_sram_mem_responder;

  typedef struct {
    logic        isWr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expRd;
    int          expStall;
    int          memIdx;
  } vec_t;

  logic clk;
  logic rst;

  logic        rdEn1, wrEn1, ready1, addrErr1, sramDqOe1, sramWeN1;
  logic [31:0] address1, wrData1, rdData1;
  logic [17:0] sramAddr1;
  logic [15:0] sramDqOut1, sramDqIn1;

  logic        rdEn3, wrEn3, ready3, addrErr3, sramDqOe3, sramWeN3;
  logic [31:0] address3, wrData3, rdData3;
  logic [17:0] sramAddr3;
  logic [15:0] sramDqOut3, sramDqIn3;

  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];
  int          run1, run3, weLow1, weLow3;
  logic [17:0] last1, last3;

  int compared;
  int mismatched;

  sram_mem_responder #(.DATA_BASE(1024), .WAIT_CYCLES(1), .SRAM_ADDR_W(18)) dut1 (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rdEn1), .wr_en_i(wrEn1),
    .address_i(address1), .wr_data_i(wrData1), .rd_data_o(rdData1),
    .ready_o(ready1), .addr_err_o(addrErr1), .sram_addr_o(sramAddr1),
    .sram_dq_out_o(sramDqOut1), .sram_dq_oe_o(sramDqOe1),
    .sram_dq_in_i(sramDqIn1), .sram_we_n_o(sramWeN1)
  );

  sram_mem_responder #(.DATA_BASE(1024), .WAIT_CYCLES(3), .SRAM_ADDR_W(18)) dut3 (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rdEn3), .wr_en_i(wrEn3),
    .address_i(address3), .wr_data_i(wrData3), .rd_data_o(rdData3),
    .ready_o(ready3), .addr_err_o(addrErr3), .sram_addr_o(sramAddr3),
    .sram_dq_out_o(sramDqOut3), .sram_dq_oe_o(sramDqOe3),
    .sram_dq_in_i(sramDqIn3), .sram_we_n_o(sramWeN3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM read path.
  assign sramDqIn1 = mem1[sramAddr1[7:0]];
  assign sramDqIn3 = mem3[sramAddr3[7:0]];

  // SRAM write model, sampled mid-cycle while the pins are stable.
  always @(negedge clk) begin
    if (!sramWeN1) weLow1++;
    if (!sramWeN1 && sramDqOe1) begin
      if (run1 > 0 && sramAddr1 == last1) run1++;
      else run1 = 1;
      last1 = sramAddr1;
      if (run1 == 1) mem1[sramAddr1[7:0]] = sramDqOut1;
    end else begin
      run1 = 0;
    end
    if (!sramWeN3) weLow3++;
    if (!sramWeN3 && sramDqOe3) begin
      if (run3 > 0 && sramAddr3 == last3) run3++;
      else run3 = 1;
      last3 = sramAddr3;
      if (run3 == 3) mem3[sramAddr3[7:0]] = sramDqOut3;
    end else begin
      run3 = 0;
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int which, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    if (which == 0) begin
      rdEn1 = rd; wrEn1 = wr; address1 = addr; wrData1 = data;
    end else begin
      rdEn3 = rd; wrEn3 = wr; address3 = addr; wrData3 = data;
    end
  endtask

  // One complete access; called just after a rising edge. Returns the number
  // of cycles ready stayed low, the load data in the ready cycle, and the
  // error flag seen in the request cycle.
  task automatic doAccess(input int which, input logic isWr, input logic [31:0] addr,
                          input logic [31:0] data, output int stall,
                          output logic [31:0] rdv, output logic errSeen);
    logic rdy;
    applyStimulus(which, !isWr, isWr, addr, data);
    stall = 0;
    errSeen = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 0) errSeen = (which == 0) ? addrErr1 : addrErr3;
      rdy = (which == 0) ? ready1 : ready3;
      if (rdy === 1'b1) break;
      stall++;
    end
    if (stall >= 64) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL access timeout: ready never rose for addr %h", addr);
    end
    rdv = (which == 0) ? rdData1 : rdData3;
    @(posedge clk);
    #1;
    applyStimulus(which, 1'b0, 1'b0, addr, data);
  endtask

  initial begin
    vec_t        vecs[8];
    int          stall;
    logic [31:0] rdv;
    logic        errSeen;
    int          weBefore;

    compared = 0;
    mismatched = 0;
    run1 = 0; run3 = 0; weLow1 = 0; weLow3 = 0;
    last1 = '0; last3 = '0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 16'h0000;
      mem3[i] = 16'h0000;
    end
    mem3[2] = 16'h5678;
    mem3[3] = 16'h1234;
    mem3[5] = 16'h7777;

    vecs[0] = '{1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000, 3, 0};
    vecs[1] = '{1'b0, 32'd1024, 32'h00000000, 32'hDEADBEEF, 3, 0};
    vecs[2] = '{1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 3, 2};
    vecs[3] = '{1'b0, 32'd1028, 32'h00000000, 32'h12345678, 3, 2};
    vecs[4] = '{1'b1, 32'd1040, 32'hA5A50F0F, 32'h12345678, 3, 8};
    vecs[5] = '{1'b1, 32'd1044, 32'hCAFEF00D, 32'h12345678, 3, 10};
    vecs[6] = '{1'b0, 32'd1040, 32'h00000000, 32'hA5A50F0F, 3, 8};
    vecs[7] = '{1'b0, 32'd1044, 32'h00000000, 32'hCAFEF00D, 3, 10};

    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset: released SRAM, ready high, load data cleared.
    $display("[TB] reset and idle checks");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("idle dut1 ready/we_n/oe", {29'd0, ready1, sramWeN1, sramDqOe1}, 32'h6);
      checkOutput("idle dut1 rd_data", rdData1, 32'h0);
      checkOutput("idle dut3 ready/we_n/oe", {29'd0, ready3, sramWeN3, sramDqOe3}, 32'h6);
      checkOutput("idle dut3 rd_data", rdData3, 32'h0);
    end
    checkOutput("reset dut1 sram_addr", {14'd0, sramAddr1}, 32'h0);
    checkOutput("reset dut1 sram_dq_out", {16'd0, sramDqOut1}, 32'h0);
    @(posedge clk);
    #1;

    // Table of back-to-back word accesses on the single-wait instance.
    $display("[TB] vector table, one wait cycle");
    for (int v = 0; v < 8; v++) begin
      weBefore = weLow1;
      doAccess(0, vecs[v].isWr, vecs[v].addr, vecs[v].data, stall, rdv, errSeen);
      checkOutput($sformatf("vec%0d stall", v), stall, vecs[v].expStall);
      checkOutput($sformatf("vec%0d rd_data", v), rdv, vecs[v].expRd);
      checkOutput($sformatf("vec%0d addr_err", v), {31'd0, errSeen}, 32'h0);
      checkOutput($sformatf("vec%0d we_n low cycles", v), weLow1 - weBefore,
                  vecs[v].isWr ? 32'd2 : 32'd0);
      if (vecs[v].isWr) begin
        checkOutput($sformatf("vec%0d sram low half", v), {16'd0, mem1[vecs[v].memIdx]},
                    {16'd0, vecs[v].data[15:0]});
        checkOutput($sformatf("vec%0d sram high half", v), {16'd0, mem1[vecs[v].memIdx + 1]},
                    {16'd0, vecs[v].data[31:16]});
      end
    end

`ifdef SRAM_ADDR_CHECK_EN
    // Rejected requests: no SRAM activity, single-cycle stall.
    $display("[TB] address check");
    weBefore = weLow1;
    doAccess(0, 1'b1, 32'd512, 32'h11112222, stall, rdv, errSeen);
    checkOutput("err store addr_err", {31'd0, errSeen}, 32'h1);
    checkOutput("err store stall", stall, 32'd1);
    checkOutput("err store no write", weLow1 - weBefore, 32'd0);
    doAccess(0, 1'b0, 32'd1026, 32'h0, stall, rdv, errSeen);
    checkOutput("err load addr_err", {31'd0, errSeen}, 32'h1);
    checkOutput("err load stall", stall, 32'd1);
    checkOutput("err load rd_data", rdv, 32'hFFFFFFFF);
    doAccess(0, 1'b0, 32'd525312, 32'h0, stall, rdv, errSeen);
    checkOutput("err oor addr_err", {31'd0, errSeen}, 32'h1);
`else
    // Address one SRAM-size past the base wraps onto word 0.
    $display("[TB] truncated address mapping");
    doAccess(0, 1'b0, 32'd525312, 32'h0, stall, rdv, errSeen);
    checkOutput("alias load stall", stall, 32'd3);
    checkOutput("alias load rd_data", rdv, 32'hDEADBEEF);
    checkOutput("alias addr_err", {31'd0, errSeen}, 32'h0);
`endif

    // Three wait cycles: seven-cycle stall, each half held three cycles.
    $display("[TB] three wait cycle load trace");
    applyStimulus(1, 1'b1, 1'b0, 32'd1028, 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput($sformatf("w3 ready c%0d", c), {31'd0, ready3}, (c < 7) ? 32'h0 : 32'h1);
      if (c >= 1 && c <= 3)
        checkOutput($sformatf("w3 sram_addr c%0d", c), {14'd0, sramAddr3}, 32'd2);
      if (c >= 4 && c <= 6)
        checkOutput($sformatf("w3 sram_addr c%0d", c), {14'd0, sramAddr3}, 32'd3);
      if (c >= 1 && c <= 6)
        checkOutput($sformatf("w3 load pins c%0d", c), {30'd0, sramWeN3, sramDqOe3}, 32'h2);
    end
    checkOutput("w3 rd_data", rdData3, 32'h12345678);
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset during the high phase of a store.
    $display("[TB] reset during store");
    applyStimulus(1, 1'b0, 1'b1, 32'd1032, 32'hAAAA5555);
    repeat (5) @(negedge clk);
    checkOutput("mid-store in high phase", {13'd0, sramWeN3, sramAddr3}, 32'd5);
    rst = 1'b1;
    applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("post-reset ready/we_n/oe", {29'd0, ready3, sramWeN3, sramDqOe3}, 32'h6);
    checkOutput("post-reset dut3 rd_data", rdData3, 32'h0);
    checkOutput("post-reset dut1 rd_data", rdData1, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("partial store low half", {16'd0, mem3[4]}, 32'h5555);
    checkOutput("partial store high half kept", {16'd0, mem3[5]}, 32'h7777);
    doAccess(1, 1'b0, 32'd1028, 32'h0, stall, rdv, errSeen);
    checkOutput("after reset stall", stall, 32'd7);
    checkOutput("after reset rd_data", rdv, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
